// File: rtl/counter_cmd_arbiter.sv
// Round-robin command arbiter for a shared event counter with autocount divider.
// Define COUNTER_ARB_SATURATE_EN to saturate instead of wrap on up/down.
module counter_cmd_arbiter #(
    parameter int              NREQ       = 4,
    parameter int              WIDTH      = 8,
    parameter int              DIVW       = 24,
    parameter logic [DIVW-1:0] DIV_RELOAD = DIVW'(24'h400000)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [2*NREQ-1:0]     req_cmd,
    input  logic [WIDTH*NREQ-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  auto_en,
    input  logic                  hold,
    output logic [WIDTH-1:0]      count,
    output logic                  tick,
    output logic                  count_eq_zero,
    output logic                  count_eq_max,
    output logic                  wrap
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    localparam logic [1:0] CMD_UP    = 2'b00;
    localparam logic [1:0] CMD_DOWN  = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;
    localparam logic [1:0] CMD_LOAD  = 2'b11;

    logic [0:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [1:0]      cmd_q, cmd_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic            pend_q, pend_d;
    logic [DIVW-1:0] div_q, div_d;
    logic            tick_q, tick_d;
    logic            wrap_q, wrap_d;
    logic            zero_q, max_q;

    logic            found;
    logic [PW-1:0]   pick;
    int              idx;

    logic [WIDTH-1:0] up_val, dn_val;
    logic            up_wr, dn_wr;
    logic            pend_any;

    // First valid requester after the last one served, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_comb begin
        up_wr = (count_q == '1);
        dn_wr = (count_q == '0);
`ifdef COUNTER_ARB_SATURATE_EN
        up_val = up_wr ? count_q : count_q + WIDTH'(1);
        dn_val = dn_wr ? count_q : count_q - WIDTH'(1);
`else
        up_val = count_q + WIDTH'(1);
        dn_val = count_q - WIDTH'(1);
`endif
    end

    assign pend_any = pend_q | (tick_q & auto_en);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        pend_d  = pend_any;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    ptr_d   = pick;
                    cmd_d   = req_cmd[2*int'(pick) +: 2];
                    data_d  = req_data[WIDTH*int'(pick) +: WIDTH];
                    state_d = S_EXEC;
                end else if (pend_any && !hold) begin
                    count_d = up_val;
                    wrap_d  = up_wr;
                    pend_d  = 1'b0;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                unique case (cmd_q)
                    CMD_UP: begin
                        if (!hold) begin
                            count_d = up_val;
                            wrap_d  = up_wr;
                        end
                    end
                    CMD_DOWN: begin
                        if (!hold) begin
                            count_d = dn_val;
                            wrap_d  = dn_wr;
                        end
                    end
                    CMD_CLEAR: begin
                        count_d = '0;
                        pend_d  = 1'b0;
                    end
                    CMD_LOAD: begin
                        count_d = data_q;
                        pend_d  = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_d  = (div_q == '0) ? DIV_RELOAD : div_q - DIVW'(1);
        tick_d = (div_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= PW'(NREQ - 1);
            grant_q <= '0;
            cmd_q   <= CMD_UP;
            data_q  <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            div_q   <= DIV_RELOAD;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            zero_q  <= 1'b1;
            max_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            zero_q  <= (count_q == '0);
            max_q   <= (count_q == '1);
        end
    end

    assign req_ready     = (state_q == S_EXEC) ? (NREQ'(1) << grant_q) : '0;
    assign count         = count_q;
    assign tick          = tick_q;
    assign wrap          = wrap_q;
    assign count_eq_zero = zero_q;
    assign count_eq_max  = max_q;
endmodule
